fifo16: RTL
===========

Name: fifo16

Overview:
- Synchronous 16-bit-wide FIFO that buffers words upstream of the 16-bit bus buffer stage.
- The FIFO's dout drives the buffer input directly.
- Decouples a bursty producer (CPU memory-mapped write, UART RX assembler) from the consumer.
- Fixed-depth circular buffer with write/read enables, full/empty flags and an occupancy count.

Parameters:
- DEPTH, 16, number of 16-bit entries; must be a power of 2, >= 2.
- ADDR_W, 4, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write request; din captured if accepted.
- din  input  16  write data.
- rd_en  input  1  read request; head word popped if accepted.
- dout  output  16  registered read data, fed to the downstream buffer.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.
- count  output  ADDR_W+1  number of stored words, 0..DEPTH.

Interface: one clock (clk); reset is synchronous and active-high (reset). Reset is sampled only on the rising edge of clk.

Behaviour:
- Reset (reset=1 at a rising edge):
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, dout=16'h0000.
  - Storage array is not cleared.
  - Reset overrides wr_en/rd_en in the same cycle.
  - Reset mid-burst discards all contents.
- Read acceptance: rd_acc = rd_en & ~empty.
- Write acceptance: wr_acc = wr_en & (~full | rd_acc). A write while full is accepted only if a read is accepted in the same cycle.
- Write: on wr_acc, mem[wr_ptr] <= din; wr_ptr <= wr_ptr+1 mod DEPTH.
- Read: on rd_acc, dout <= mem[rd_ptr]; rd_ptr <= rd_ptr+1 mod DEPTH.
  - dout is valid the cycle after rd_en is sampled high (1-cycle read latency).
  - dout holds its last value when no read is accepted.
- Count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
- Flags: full and empty are registered, derived from the next count value, and valid in the same cycle as count. Never both high.
- Empty with wr_en=1 and rd_en=1: write accepted, read ignored. count 0->1. dout unchanged; the new word is not bypassed.
- Full with wr_en=1 and rd_en=1: both accepted. count stays DEPTH, full stays 1. Oldest word goes to dout; din occupies the freed slot.
- Rejected operations:
  - Write while full (no read) is dropped; state unchanged.
  - Read while empty is dropped; dout unchanged.
- Pointer wrap-around is modulo DEPTH with no special casing. Order is strictly first-in first-out across the wrap.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: FIFO16_ERROR_FLAGS_EN
- Defined: adds two outputs, overflow (1 bit) and underflow (1 bit), both reset to 0.
  - overflow sets at the edge where wr_en=1 and the write is rejected.
  - underflow sets at the edge where rd_en=1 and empty=1.
  - Both are sticky until reset and do not affect data path behaviour.
- Undefined: the ports do not exist; rejected operations are silently dropped as above.

Test Plan:
- Reset, then idle 3 cycles -> empty=1, full=0, count=0, dout=16'h0000.
- Write 16'hA5A5, 16'h0001, 16'hFFFF on consecutive cycles, then read 3 times -> dout shows A5A5, 0001, FFFF one cycle after each read; count ends at 0; empty=1.
- Fill DEPTH=16 words (values 0..15), then 1 extra write of 16'hDEAD -> full=1, count=16, DEAD dropped.
  - With the macro defined, overflow=1.
  - Draining returns 0..15.
- When full, assert wr_en+rd_en with din=16'h1234 -> dout=0 (oldest), count stays 16, full stays 1. After draining, 1234 is the last word out.
- When empty, assert wr_en+rd_en with din=16'h00FF -> count=1, dout unchanged. Next read yields 00FF.
  - With the macro defined, read on empty sets underflow=1.
- Push/pop 10000 random words with random enables across many pointer wraps, checked against a queue model; assert reset mid-stream -> count=0, empty=1, dout=0 next cycle, and the old contents never appear again.

Source files
------------

// File: rtl/fifo16.sv
// fifo16: synchronous 16-bit FIFO with registered read data, full/empty flags
// and an occupancy count. It sits in front of the 16-bit bus buffer stage.
// Optional build macro FIFO16_ERROR_FLAGS_EN adds sticky overflow/underflow
// outputs. When the macro is undefined, those ports do not exist.
module fifo16 #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [15:0]       din,
  input  logic              rd_en,
  output logic [15:0]       dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
`ifdef FIFO16_ERROR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_acc;
  logic              wr_acc;
  logic [ADDR_W:0]   count_next;

  // Accept logic: a write into a full FIFO proceeds only when a read frees a slot in the same cycle.
  always_comb begin
    rd_acc     = rd_en & ~empty;
    wr_acc     = wr_en & (~full | rd_acc);
    count_next = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage is intentionally not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, registered read data, count and flags.
  // The flags come from count_next so they line up with count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= 16'h0000;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == DEPTH_C);
    end
  end

`ifdef FIFO16_ERROR_FLAGS_EN
  // Sticky error flags for rejected writes and reads; they have no effect on the data path.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_acc) overflow  <= 1'b1;
      if (rd_en && empty)   underflow <= 1'b1;
    end
  end
`endif

endmodule
